// File: rtl/osc_sweep_pkg.sv
// Shared types for the oscillator sweep sequencer: FSM state, coefficient width and pair struct.
package osc_sweep_pkg;

  localparam int unsigned COEF_W      = 32;
  localparam int unsigned COEF_FRAC_W = 29;
  // 1.0 in signed Q2.29
  localparam logic signed [COEF_W-1:0] COEF_ONE = 32'sd1 <<< COEF_FRAC_W;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StRun,
    StNext,
    StDone
  } sweep_state_e;

  typedef struct packed {
    logic [COEF_W-1:0] sin_b;
    logic [COEF_W-1:0] cos2_b;
  } coef_pair_t;

endpackage

// File: rtl/osc_sweep_ctrl_if.sv
// Host-side and oscillator-side signal bundle of the sweep sequencer.
interface osc_sweep_ctrl_if
  import osc_sweep_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) ();

  logic              CoefWr;
  logic [ADDR_W-1:0] CoefAddr;
  logic [COEF_W-1:0] CoefSin;
  logic [COEF_W-1:0] CoefCos2;
  logic [ADDR_W:0]   NumPoints;
  logic [CNT_W-1:0]  SamplesPerPoint;
  logic              Tick;
  logic              Start;
  logic              Abort;

  logic              Osc_Ready;
  logic              Osc_Enable;
  logic [COEF_W-1:0] Osc_Init1;
  logic [COEF_W-1:0] Osc_Init2;
  logic [ADDR_W-1:0] PointIdx;
  logic              PointStart;
  logic              SampleValid;
  logic              Busy;
  logic              Done;

  modport master (
    output CoefWr, CoefAddr, CoefSin, CoefCos2, NumPoints, SamplesPerPoint, Tick, Start, Abort,
    input  Osc_Ready, Osc_Enable, Osc_Init1, Osc_Init2, PointIdx, PointStart, SampleValid,
           Busy, Done
  );

  modport slave (
    input  CoefWr, CoefAddr, CoefSin, CoefCos2, NumPoints, SamplesPerPoint, Tick, Start, Abort,
    output Osc_Ready, Osc_Enable, Osc_Init1, Osc_Init2, PointIdx, PointStart, SampleValid,
           Busy, Done
  );

endinterface

// File: rtl/osc_coef_table.sv
// Per-point coefficient store: synchronous write, registered read. Array contents are not reset.
module osc_coef_table
  import osc_sweep_pkg::*;
#(
  parameter int unsigned MAX_POINTS = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  coef_pair_t        i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output coef_pair_t        o_rd_data
);

  coef_pair_t r_mem [MAX_POINTS];
  coef_pair_t r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/osc_sweep_ctrl.sv
// Frequency-sweep sequencer driving the recursive sine oscillator load/enable pins.
// Define SWEEP_LOOP_EN to wrap back to point 0 after the last point instead of stopping in DONE.
module osc_sweep_ctrl
  import osc_sweep_pkg::*;
#(
  parameter int unsigned MAX_POINTS = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 8
) (
  input logic              Fg_CLK,
  input logic              Fg_RESET,
  osc_sweep_ctrl_if.slave  bus
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

  sweep_state_e      r_state, w_state_d;
  logic [ADDR_W-1:0] r_idx, w_idx_d;
  logic [ADDR_W:0]   r_np, w_np_d, w_np_in;
  logic [CNT_W-1:0]  r_spp, w_spp_d;
  logic [CNT_W-1:0]  r_samp, w_samp_d;
  logic [SET_W-1:0]  r_settle, w_settle_d;
  logic              r_sample_valid, r_point_start, r_done, w_done_d;
  logic              w_ready, w_enable, w_last, w_wr_en, w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  coef_pair_t        w_wr_data, w_rd_data;

  assign w_wr_en   = bus.CoefWr && (r_state == StIdle);
  assign w_wr_data = '{sin_b: bus.CoefSin, cos2_b: bus.CoefCos2};
  assign w_last    = ({1'b0, r_idx} == (r_np - (ADDR_W+1)'(1)));
  // Out-of-range point counts are clamped so the index never leaves the table
  assign w_np_in   = (bus.NumPoints > (ADDR_W+1)'(MAX_POINTS)) ? (ADDR_W+1)'(MAX_POINTS)
                                                               : bus.NumPoints;

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_np_d     = r_np;
    w_spp_d    = r_spp;
    w_samp_d   = r_samp;
    w_settle_d = r_settle;
    w_done_d   = 1'b0;
    w_ready    = 1'b0;
    w_enable   = 1'b0;
    w_rd_en    = 1'b0;
    w_rd_addr  = r_idx;
    if (bus.Abort) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (bus.Start) begin
            w_np_d   = w_np_in;
            w_spp_d  = bus.SamplesPerPoint;
            w_idx_d  = '0;
            w_samp_d = '0;
            if ((bus.NumPoints == '0) || (bus.SamplesPerPoint == '0)) begin
              w_state_d = StDone;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = StLoad;
              w_rd_en   = 1'b1;
              w_rd_addr = '0;
            end
          end
        end
        StLoad: begin
          w_ready    = 1'b1;
          w_settle_d = '0;
          w_state_d  = StSettle;
        end
        StSettle: begin
          if (r_settle == SET_W'(SETTLE_CYC - 1)) begin
            w_state_d = StRun;
            w_samp_d  = '0;
          end else begin
            w_settle_d = r_settle + SET_W'(1);
          end
        end
        StRun: begin
          if (bus.Tick) begin
            w_enable = 1'b1;
            w_samp_d = r_samp + CNT_W'(1);
            if ((r_samp + CNT_W'(1)) == r_spp) begin
              w_state_d = StNext;
            end
          end
        end
        StNext: begin
          if (w_last) begin
`ifdef SWEEP_LOOP_EN
            w_idx_d   = '0;
            w_rd_en   = 1'b1;
            w_rd_addr = '0;
            w_state_d = StLoad;
            w_done_d  = 1'b1;
`else
            w_state_d = StDone;
            w_done_d  = 1'b1;
`endif
          end else begin
            w_idx_d   = r_idx + ADDR_W'(1);
            w_rd_en   = 1'b1;
            w_rd_addr = r_idx + ADDR_W'(1);
            w_state_d = StLoad;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (Fg_RESET) begin
      r_state        <= StIdle;
      r_idx          <= '0;
      r_np           <= '0;
      r_spp          <= '0;
      r_samp         <= '0;
      r_settle       <= '0;
      r_sample_valid <= 1'b0;
      r_point_start  <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_idx          <= w_idx_d;
      r_np           <= w_np_d;
      r_spp          <= w_spp_d;
      r_samp         <= w_samp_d;
      r_settle       <= w_settle_d;
      r_sample_valid <= w_enable;
      r_point_start  <= w_enable && (r_samp == '0);
      r_done         <= w_done_d;
    end
  end

  osc_coef_table #(
    .MAX_POINTS(MAX_POINTS),
    .ADDR_W    (ADDR_W)
  ) u_coef_table (
    .i_clk    (Fg_CLK),
    .i_rst    (Fg_RESET),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(bus.CoefAddr),
    .i_wr_data(w_wr_data),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  assign bus.Osc_Ready   = w_ready;
  assign bus.Osc_Enable  = w_enable;
  assign bus.Osc_Init1   = w_rd_data.sin_b;
  assign bus.Osc_Init2   = w_rd_data.cos2_b;
  assign bus.PointIdx    = r_idx;
  assign bus.PointStart  = r_point_start;
  assign bus.SampleValid = r_sample_valid;
  assign bus.Busy        = (r_state != StIdle) && (r_state != StDone);
  assign bus.Done        = r_done;

endmodule

// File: tb/tb_osc_sweep_ctrl.sv
// Directed self-checking bench for osc_sweep_ctrl; loop-mode checks build only with SWEEP_LOOP_EN.
module tb_osc_sweep_ctrl;
  import osc_sweep_pkg::*;

  localparam int SETTLE = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  osc_sweep_ctrl_if #(.ADDR_W(4), .CNT_W(16)) bus ();

  osc_sweep_ctrl #(
    .MAX_POINTS(16),
    .ADDR_W    (4),
    .CNT_W     (16),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .Fg_CLK  (clk),
    .Fg_RESET(rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc, done_cyc;
  int n_en, n_sv, n_ps, n_done, n_en_no_tick, n_lag_err;
  logic prev_en = 1'b0;
  logic [31:0] rdy_sin[$];
  logic [31:0] rdy_cos[$];
  logic [3:0]  rdy_idx[$];
  int          rdy_cyc[$];
  int          en_cyc[$];

  task automatic clear_stats();
    n_en = 0; n_sv = 0; n_ps = 0; n_done = 0; n_en_no_tick = 0; n_lag_err = 0;
    done_cyc = -1;
    rdy_sin.delete(); rdy_cos.delete(); rdy_idx.delete(); rdy_cyc.delete(); en_cyc.delete();
  endtask

  // One clock cycle: observe at negedge, then step past the rising edge and drop pulses.
  task automatic run_cycle(input logic tick);
    bus.Tick = tick;
    @(negedge clk);
    if (bus.Osc_Ready) begin
      rdy_sin.push_back(bus.Osc_Init1);
      rdy_cos.push_back(bus.Osc_Init2);
      rdy_idx.push_back(bus.PointIdx);
      rdy_cyc.push_back(cyc);
    end
    if (bus.Osc_Enable) begin
      n_en++;
      en_cyc.push_back(cyc);
      if (!bus.Tick) n_en_no_tick++;
    end
    if (bus.SampleValid !== prev_en) n_lag_err++;
    if (bus.SampleValid) n_sv++;
    if (bus.PointStart) n_ps++;
    if (bus.Done) begin n_done++; done_cyc = cyc; end
    prev_en = bus.Osc_Enable;
    @(posedge clk);
    #1;
    bus.Start  = 1'b0;
    bus.Abort  = 1'b0;
    bus.CoefWr = 1'b0;
    cyc++;
  endtask

  task automatic start_sweep(input logic [4:0] np, input logic [15:0] spp, input logic tick);
    bus.NumPoints       = np;
    bus.SamplesPerPoint = spp;
    bus.Start           = 1'b1;
    start_cyc           = cyc;
    run_cycle(tick);
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [31:0] s, input logic [31:0] c);
    bus.CoefWr = 1'b1; bus.CoefAddr = a; bus.CoefSin = s; bus.CoefCos2 = c;
    run_cycle(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run_cycle(1'b0);
    run_cycle(1'b0);
    n_tests++;
    if ({bus.Osc_Ready, bus.Osc_Enable, bus.Osc_Init1, bus.Osc_Init2, bus.PointIdx,
         bus.PointStart, bus.SampleValid, bus.Busy, bus.Done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got Busy=%b Init1=%h Idx=%0d want all zero",
               bus.Busy, bus.Osc_Init1, bus.PointIdx);
    end
    rst = 1'b0;
    run_cycle(1'b0);
  endtask

  task automatic test_basic();
    write_coef(4'd0, 32'h0B504F33, 32'h16A09E66);
    write_coef(4'd1, 32'h10000000, 32'h1BB67AE8);
    write_coef(4'd2, 32'h12345678, 32'h0ABCDEF0);
    clear_stats();
    start_sweep(5'd2, 16'd4, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i == 4) bus.Start = 1'b1;  // lands in SETTLE, must be ignored
      run_cycle(1'b1);
    end
    n_tests++;
    if (rdy_sin.size() != 2) begin
      n_fail++; $display("FAIL basic_ready_count got %0d want 2", rdy_sin.size());
    end
    n_tests++;
    if ({rdy_sin[0], rdy_cos[0]} !== {32'h0B504F33, 32'h16A09E66}) begin
      n_fail++; $display("FAIL basic_point0_coef got %h/%h want 0b504f33/16a09e66",
                         rdy_sin[0], rdy_cos[0]);
    end
    n_tests++;
    if ({rdy_sin[1], rdy_cos[1], rdy_idx[1]} !== {32'h10000000, 32'h1BB67AE8, 4'd1}) begin
      n_fail++; $display("FAIL basic_point1_coef got %h/%h idx %0d want 10000000/1bb67ae8 idx 1",
                         rdy_sin[1], rdy_cos[1], rdy_idx[1]);
    end
    n_tests++;
    if (rdy_cyc[0] - start_cyc !== 1) begin
      n_fail++; $display("FAIL start_to_ready got %0d want 1", rdy_cyc[0] - start_cyc);
    end
    n_tests++;
    if ((en_cyc[0] - rdy_cyc[0] !== SETTLE + 1) || (en_cyc[4] - rdy_cyc[1] !== SETTLE + 1)) begin
      n_fail++; $display("FAIL ready_to_enable got %0d,%0d want %0d", en_cyc[0] - rdy_cyc[0],
                         en_cyc[4] - rdy_cyc[1], SETTLE + 1);
    end
    n_tests++;
    if ({n_en, n_sv, n_ps, n_done} !== {32'd8, 32'd8, 32'd2, 32'd1}) begin
      n_fail++; $display("FAIL basic_counts got en=%0d sv=%0d ps=%0d done=%0d want 8 8 2 1",
                         n_en, n_sv, n_ps, n_done);
    end
    n_tests++;
    if ((n_lag_err !== 0) || (bus.Busy !== 1'b0)) begin
      n_fail++; $display("FAIL basic_lag_busy got lagerr=%0d busy=%b want 0 0", n_lag_err, bus.Busy);
    end
  endtask

  task automatic test_sparse_tick();
    clear_stats();
    start_sweep(5'd1, 16'd5, 1'b0);
    for (int i = 0; i < 120 && n_done == 0; i++) run_cycle((i % 3) == 0);
    run_cycle(1'b0);
    n_tests++;
    if ({n_en, n_sv, n_ps, n_done} !== {32'd5, 32'd5, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL sparse_counts got en=%0d sv=%0d ps=%0d done=%0d want 5 5 1 1",
                         n_en, n_sv, n_ps, n_done);
    end
    n_tests++;
    if ((n_en_no_tick !== 0) || (n_lag_err !== 0)) begin
      n_fail++; $display("FAIL sparse_tick_align got notick=%0d lagerr=%0d want 0 0",
                         n_en_no_tick, n_lag_err);
    end
    n_tests++;
    if (en_cyc[1] - en_cyc[0] !== 3) begin
      n_fail++; $display("FAIL sparse_spacing got %0d want 3", en_cyc[1] - en_cyc[0]);
    end
  endtask

  task automatic test_abort();
    clear_stats();
    start_sweep(5'd2, 16'd4, 1'b1);
    for (int i = 0; i < 60 && n_en < 6; i++) run_cycle(1'b1);
    bus.Abort = 1'b1;
    run_cycle(1'b1);
    n_tests++;
    if ((n_en !== 6) || (bus.Busy !== 1'b0)) begin
      n_fail++; $display("FAIL abort_cycle got en=%0d busy=%b want 6 0", n_en, bus.Busy);
    end
    for (int i = 0; i < 20; i++) run_cycle(1'b1);
    n_tests++;
    if ({n_en, rdy_sin.size(), n_done} !== {32'd6, 32'd2, 32'd0}) begin
      n_fail++; $display("FAIL abort_quiet got en=%0d ready=%0d done=%0d want 6 2 0",
                         n_en, rdy_sin.size(), n_done);
    end
    clear_stats();
    start_sweep(5'd2, 16'd4, 1'b1);
    for (int i = 0; i < 60 && n_done == 0; i++) run_cycle(1'b1);
    n_tests++;
    if ({rdy_idx[0], rdy_sin[0], n_done} !== {4'd0, 32'h0B504F33, 32'd1}) begin
      n_fail++; $display("FAIL abort_restart got idx=%0d sin=%h done=%0d want 0 0b504f33 1",
                         rdy_idx[0], rdy_sin[0], n_done);
    end
  endtask

  task automatic test_zero_points();
    clear_stats();
    start_sweep(5'd0, 16'd4, 1'b1);
    for (int i = 0; i < 5; i++) run_cycle(1'b1);
    n_tests++;
    if ((n_done !== 1) || (done_cyc - start_cyc < 1) || (done_cyc - start_cyc > 2)) begin
      n_fail++; $display("FAIL zero_points_done got count=%0d delay=%0d want 1 within 2",
                         n_done, done_cyc - start_cyc);
    end
    n_tests++;
    if ((rdy_sin.size() !== 0) || (bus.Busy !== 1'b0)) begin
      n_fail++; $display("FAIL zero_points_ready got ready=%0d busy=%b want 0 0",
                         rdy_sin.size(), bus.Busy);
    end
  endtask

  task automatic test_coef_write_in_run();
    clear_stats();
    start_sweep(5'd1, 16'd4, 1'b1);
    for (int i = 0; i < 40 && n_en == 0; i++) run_cycle(1'b1);
    bus.CoefWr = 1'b1; bus.CoefAddr = 4'd0; bus.CoefSin = 32'hDEADBEEF; bus.CoefCos2 = 32'hCAFEF00D;
    run_cycle(1'b1);
    for (int i = 0; i < 40 && n_done == 0; i++) run_cycle(1'b1);
    clear_stats();
    start_sweep(5'd1, 16'd4, 1'b1);
    for (int i = 0; i < 40 && n_done == 0; i++) run_cycle(1'b1);
    n_tests++;
    if ({rdy_sin[0], rdy_cos[0]} !== {32'h0B504F33, 32'h16A09E66}) begin
      n_fail++; $display("FAIL coef_write_in_run got %h/%h want 0b504f33/16a09e66",
                         rdy_sin[0], rdy_cos[0]);
    end
  endtask

  task automatic test_reset_mid_settle();
    clear_stats();
    start_sweep(5'd1, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(1'b1);
    rst = 1'b1;
    bus.Start = 1'b1;
    run_cycle(1'b1);
    n_tests++;
    if ({bus.Osc_Ready, bus.Osc_Enable, bus.Osc_Init1, bus.Osc_Init2, bus.PointIdx,
         bus.PointStart, bus.SampleValid, bus.Busy, bus.Done} !== '0) begin
      n_fail++; $display("FAIL reset_mid_settle got Busy=%b Init1=%h want all zero",
                         bus.Busy, bus.Osc_Init1);
    end
    for (int i = 0; i < 3; i++) begin
      bus.Start = 1'b1;
      run_cycle(1'b1);
    end
    n_tests++;
    if ({rdy_sin.size(), n_en, 31'd0, bus.Busy} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_held got ready=%0d en=%0d busy=%b want 1 0 0",
                         rdy_sin.size(), n_en, bus.Busy);
    end
    rst = 1'b0;
    clear_stats();
    start_sweep(5'd2, 16'd4, 1'b1);
    for (int i = 0; i < 60 && n_done == 0; i++) run_cycle(1'b1);
    n_tests++;
    if ({rdy_sin[0], rdy_sin[1]} !== {32'h0B504F33, 32'h10000000}) begin
      n_fail++; $display("FAIL reset_table_kept got %h/%h want 0b504f33/10000000",
                         rdy_sin[0], rdy_sin[1]);
    end
  endtask

`ifdef SWEEP_LOOP_EN
  task automatic test_loop();
    clear_stats();
    start_sweep(5'd3, 16'd2, 1'b1);
    for (int i = 0; i < 200 && rdy_idx.size() < 5; i++) run_cycle(1'b1);
    n_tests++;
    if ({rdy_idx[0], rdy_idx[1], rdy_idx[2], rdy_idx[3], rdy_idx[4]} !==
        {4'd0, 4'd1, 4'd2, 4'd0, 4'd1}) begin
      n_fail++; $display("FAIL loop_idx_seq got %0d %0d %0d %0d %0d want 0 1 2 0 1",
                         rdy_idx[0], rdy_idx[1], rdy_idx[2], rdy_idx[3], rdy_idx[4]);
    end
    n_tests++;
    if (n_done !== 1) begin
      n_fail++; $display("FAIL loop_done_once got %0d want 1", n_done);
    end
    for (int i = 0; i < 50; i++) run_cycle(1'b1);
    n_tests++;
    if (bus.Busy !== 1'b1) begin
      n_fail++; $display("FAIL loop_keeps_running got busy=%b want 1", bus.Busy);
    end
    bus.Abort = 1'b1;
    run_cycle(1'b1);
    n_tests++;
    if (bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL loop_abort got busy=%b want 0", bus.Busy);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.CoefWr = 1'b0; bus.CoefAddr = '0; bus.CoefSin = '0; bus.CoefCos2 = '0;
    bus.NumPoints = '0; bus.SamplesPerPoint = '0; bus.Tick = 1'b0;
    bus.Start = 1'b0; bus.Abort = 1'b0;
    clear_stats();
    test_reset();
    test_basic();
    test_sparse_tick();
    test_abort();
    test_zero_points();
    test_coef_write_in_run();
    test_reset_mid_settle();
`ifdef SWEEP_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/osc_sweep_ctrl.md
Name: osc_sweep_ctrl

Overview:
Frequency-sweep sequencer for the recursive digital sine oscillator of the impedance analyzer.
- Holds a table of per-point coefficient pairs (sin(b), 2cos(b)).
- Drives the oscillator's Ready/init_1/init_2/Enable pins.
- Steps through NumPoints frequencies, generating SamplesPerPoint oscillator updates per point, with a settle gap between points.
- Sits between the host register block and the oscillator; downstream measurement logic uses its point/sample strobes.

Parameters:
- MAX_POINTS, 16, coefficient table depth.
- ADDR_W, 4, table index width, log2(MAX_POINTS).
- CNT_W, 16, sample counter width.
- SETTLE_CYC, 8, idle cycles after each point load before sampling starts (SETTLE_CYC >= 1).

Ports:
- Fg_CLK  in  1  system clock.
- Fg_RESET  in  1  synchronous, active-high reset.
- CoefWr  in  1  table write strobe (accepted only in IDLE).
- CoefAddr  in  ADDR_W  write index.
- CoefSin  in  32  sin(b), signed Q2.29.
- CoefCos2  in  32  2cos(b), signed Q2.29.
- NumPoints  in  ADDR_W+1  points to sweep, 1..MAX_POINTS; sampled on Start.
- SamplesPerPoint  in  CNT_W  oscillator updates per point; sampled on Start.
- Tick  in  1  sample-rate strobe; one oscillator update per Tick in RUN.
- Start  in  1  begin sweep (pulse, honoured in IDLE/DONE only).
- Abort  in  1  stop sweep, return to IDLE.
- Osc_Ready  out  1  load strobe to oscillator.
- Osc_Enable  out  1  oscillator update enable.
- Osc_Init1  out  32  sin(b) of the current point.
- Osc_Init2  out  32  2cos(b) of the current point.
- PointIdx  out  ADDR_W  current point index.
- PointStart  out  1  1-cycle pulse on the first sample of each point.
- SampleValid  out  1  1-cycle pulse, oscillator output updated this cycle.
- Busy  out  1  high outside IDLE/DONE.
- Done  out  1  1-cycle pulse at sweep end.

Behaviour:
- Reset (synchronous, Fg_RESET=1 at the edge): state IDLE. All outputs 0, counters 0. Table contents are not reset.
- States: IDLE, LOAD, SETTLE, RUN, NEXT, DONE.
- IDLE:
  - CoefWr writes {CoefSin, CoefCos2} to table[CoefAddr]; CoefWr in any other state is ignored.
  - Start latches NumPoints and SamplesPerPoint, sets PointIdx=0, goes to LOAD.
  - If NumPoints==0 or SamplesPerPoint==0: go straight to DONE with a Done pulse; no Ready is issued.
- LOAD (1 cycle):
  - Osc_Ready=1; Osc_Init1/Osc_Init2 = table[PointIdx], registered and stable from this cycle until the next LOAD.
  - Next state SETTLE; settle counter cleared.
- SETTLE: count SETTLE_CYC cycles, then RUN. Osc_Enable=0.
- RUN:
  - Osc_Enable = Tick (combinational gate of the registered RUN state); SampleValid = Osc_Enable delayed 1 cycle.
  - The sample counter increments per Tick.
  - PointStart pulses on the cycle of the first SampleValid of the point.
  - When the counter reaches SamplesPerPoint on a Tick, go to NEXT; no further Enable is issued.
- NEXT (1 cycle):
  - If PointIdx == NumPoints-1, go to DONE.
  - Otherwise PointIdx+1, go to LOAD.
- DONE: Done pulses 1 cycle on entry, Busy=0, state holds. Start restarts the sweep exactly as from IDLE.
- Abort:
  - In any state other than IDLE, Abort forces IDLE next cycle: Enable/Ready forced 0 that cycle, no Done pulse.
  - Abort has priority over Start and Tick.
- Start while Busy is ignored. A Tick outside RUN is ignored.
- Latency: Start to Osc_Ready = 1 cycle. Ready to first possible Enable = SETTLE_CYC+1 cycles.
- The 32-bit coefficients pass through unmodified; no arithmetic on them.

Optional Feature:
- SWEEP_LOOP_EN defined:
  - At the last point, NEXT returns to LOAD with PointIdx=0 (wrap-around) instead of DONE.
  - Done pulses once per completed pass.
  - The sweep ends only on Abort.
- SWEEP_LOOP_EN undefined: single pass, ends in DONE.

Decomposition:
- Package osc_sweep_pkg holds:
  - the state enum;
  - COEF_W=32 and the Q2.29 fraction constant;
  - a struct pairing sin and 2cos.
- One sub-module, osc_coef_table:
  - MAX_POINTS x 64 register array;
  - synchronous write, registered read addressed by PointIdx.
  - The read is issued in NEXT or at Start so data is valid in LOAD.

Test Plan:
- Load table[0]=0x0B504F33/0x16A09E66, [1]=0x10000000/0x1BB67AE8; NumPoints=2, SamplesPerPoint=4, Tick every cycle.
  - Expect 2 Ready pulses carrying those values, each followed by SETTLE_CYC idle cycles.
  - Expect 4 Enables per point, PointStart twice, Done once, Busy low afterwards.
- Tick every 3rd cycle, SamplesPerPoint=5 -> exactly 5 Enables, each coincident with a Tick; SampleValid lags Enable by 1 cycle.
- Abort asserted during RUN at sample 2 of point 1 -> IDLE next cycle, no Done, no further Enable/Ready; a following Start restarts at PointIdx=0.
- NumPoints=0 with Start -> Done pulse within 2 cycles, Osc_Ready never asserted. CoefWr during RUN leaves the table unchanged (read back on the next sweep).
- Fg_RESET asserted mid-SETTLE -> all outputs 0 on the next edge; table contents preserved; Start/Tick ignored while reset is held.
- SWEEP_LOOP_EN, NumPoints=3 -> PointIdx sequence 0,1,2,0,1; Done pulses after the first pass; stops only on Abort.
